// File: rtl/wallace_pkg.sv
// Shared constants and types for the wallace 32x32 multiplier.
// LATENCY follows the WALLACE_PIPE3_EN build option.
package wallace_pkg;

    localparam int WIDTH  = 32;
    localparam int PWIDTH = 64;

`ifdef WALLACE_PIPE3_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

    typedef logic [PWIDTH-1:0] row_t;

    // Rows left after l layers of 3:2 compression starting from WIDTH rows.
    function automatic int rows_at(input int l);
        int n;
        n = WIDTH;
        for (int k = 0; k < l; k++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    localparam int LAYERS    = 8;   // 32,22,15,10,7,5,4,3,2
    localparam int MID_LAYER = 5;   // first layer output with at most 6 rows
    localparam int MID_ROWS  = rows_at(MID_LAYER);

endpackage

// File: rtl/wallace_csa.sv
// Parameterized-width 3:2 carry-save compressor (one full adder per bit).
module wallace_csa #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    // Top carry bit falls off: the product is exact modulo 2^64.
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/wallace.sv
// Pipelined unsigned 32x32 Wallace-tree multiplier, 64-bit product.
// Build option WALLACE_PIPE3_EN adds a register mid-tree (latency 3 instead of 2).
module wallace
    import wallace_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    output logic [PWIDTH-1:0] p
);

    row_t tree [0:LAYERS][0:WIDTH-1];
    row_t lin  [0:LAYERS-1][0:WIDTH-1];
    row_t s1_sum;
    row_t s1_carry;
    logic s1_valid;
    logic tree_valid;

    genvar i, l, g, r;

    for (i = 0; i < WIDTH; i++) begin : g_pp
        assign tree[0][i] = b[i] ? (row_t'(a) << i) : '0;
    end

`ifdef WALLACE_PIPE3_EN
    row_t mid [0:MID_ROWS-1];
    logic mid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MID_ROWS; k++) mid[k] <= '0;
            mid_valid <= 1'b0;
        end else begin
            for (int k = 0; k < MID_ROWS; k++) mid[k] <= tree[MID_LAYER][k];
            mid_valid <= in_valid;
        end
    end

    assign tree_valid = mid_valid;
`else
    assign tree_valid = in_valid;
`endif

    // Layer inputs; unused row slots are tied to zero so no column carries X.
    for (l = 0; l < LAYERS; l++) begin : g_lin
        for (r = 0; r < WIDTH; r++) begin : g_row
`ifdef WALLACE_PIPE3_EN
            if (l == MID_LAYER) begin : g_mid
                if (r < MID_ROWS) begin : g_reg
                    assign lin[l][r] = mid[r];
                end else begin : g_zero
                    assign lin[l][r] = '0;
                end
            end else begin : g_pass
                assign lin[l][r] = tree[l][r];
            end
`else
            assign lin[l][r] = tree[l][r];
`endif
        end
    end

    for (l = 0; l < LAYERS; l++) begin : g_layer
        localparam int N = rows_at(l);
        localparam int G = N / 3;
        localparam int M = rows_at(l + 1);

        for (g = 0; g < G; g++) begin : g_csa
            wallace_csa #(.W(PWIDTH)) u_csa (
                .x    (lin[l][3*g]),
                .y    (lin[l][3*g+1]),
                .z    (lin[l][3*g+2]),
                .sum  (tree[l+1][2*g]),
                .carry(tree[l+1][2*g+1])
            );
        end
        for (r = 0; r < N - 3*G; r++) begin : g_fwd
            assign tree[l+1][2*G+r] = lin[l][3*G+r];
        end
        for (r = M; r < WIDTH; r++) begin : g_pad
            assign tree[l+1][r] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum    <= '0;
            s1_carry  <= '0;
            s1_valid  <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_sum    <= tree[LAYERS][0];
            s1_carry  <= tree[LAYERS][1];
            s1_valid  <= tree_valid;
            p         <= s1_sum + s1_carry;
            out_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_wallace.sv
// Self-checking bench for wallace: directed vector table, random pairs, reset mid-stream.
module tb_wallace;
    import wallace_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [63:0] p;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    wallace dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .p        (p)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic [63:0] ve);
        vec_t v;
        v.a = va; v.b = vb; v.exp = ve;
        vecs.push_back(v);
    endtask

    // Streams every vector back to back, checking each at the fixed latency.
    task automatic run_stream();
        int n;
        int j;
        n = vecs.size();
        for (int k = 0; k < n + LATENCY; k++) begin
            @(negedge clk);
            if (k < n) begin
                in_valid = 1'b1; a = vecs[k].a; b = vecs[k].b;
            end else begin
                in_valid = 1'b0; a = '0; b = '0;
            end
            @(posedge clk); #1;
            j = k - (LATENCY - 1);
            if (j >= 0 && j < n) begin
                check1($sformatf("valid[%0d]", j), out_valid, 1'b1);
                check64($sformatf("p[%0d] %h*%h", j, vecs[j].a, vecs[j].b), p, vecs[j].exp);
            end else begin
                check1($sformatf("idle_valid[%0d]", k), out_valid, 1'b0);
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        #12;
        check1("reset_valid", out_valid, 1'b0);
        check64("reset_p", p, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        add(32'h0080_0000, 32'h0080_0000, 64'h0000_4000_0000_0000);
        add(32'h00FA_4000, 32'h00C1_0000, 64'h0000_BCAA_4000_0000);
        add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        add(32'h1234_5678, 32'h0,         64'h0);
        add(32'h0,         32'hFFFF_FFFF, 64'h0);
        add(32'h1,         32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF);
        add(32'd3,         32'd5,         64'd15);
        add(32'd7,         32'd11,        64'd77);
        add(32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
        add(32'h8000_0000, 32'h2,         64'h0000_0001_0000_0000);
        add(32'hFFFF_FFFF, 32'h2,         64'h0000_0001_FFFF_FFFE);
        add(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        for (int k = 0; k < 300; k++) begin
            ra = $urandom;
            rb = $urandom;
            add(ra, rb, {32'h0, ra} * {32'h0, rb});
        end
        run_stream();

        // Two ops in flight, then reset between clock edges.
        @(negedge clk); in_valid = 1'b1; a = 32'd9;  b = 32'd9;
        @(negedge clk); in_valid = 1'b1; a = 32'd10; b = 32'd10;
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check1("rst_async_valid", out_valid, 1'b0);
        check64("rst_async_p", p, 64'h0);
        @(posedge clk); #1;
        check1("rst_hold_valid", out_valid, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < LATENCY + 1; k++) begin
            @(posedge clk); #1;
            check1($sformatf("no_stale_valid[%0d]", k), out_valid, 1'b0);
        end

        vecs.delete();
        add(32'd6, 32'd7, 64'd42);
        run_stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
